// File: rtl/dma_controller_if.sv
// Bus signals of the DMA controller: register-slave side (s_*) and bus-master side (m_*).
// The controller binds the slave modport for register access and the master modport for transfers.
interface dma_controller_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              s_sel;
    logic              s_wr;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_din;
    logic [DATA_W-1:0] s_dout;

    logic              m_req;
    logic              m_grant;
    logic              m_wr;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_dout;
    logic [DATA_W-1:0] m_din;

    modport slave  (input s_sel, s_wr, s_addr, s_din, output s_dout);
    modport master (output m_req, m_wr, m_addr, m_dout, input m_grant, m_din);
endinterface

// File: rtl/dma_controller.sv
// Single-channel DMA engine: register slave for programming, bus master for read/write word moves.
// Define DMAC_IRQ_EN to add the INT register (offset 0x05) and the dma_irq completion output.
module dma_controller #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    dma_controller_if.slave  s_bus,
    dma_controller_if.master m_bus
`ifdef DMAC_IRQ_EN
    ,
    output logic             dma_irq
`endif
);
    typedef enum logic [2:0] {IDLE, REQ, RD, RWAIT, WR, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] src_r, dst_r, src_c, dst_c;
    logic [CNT_W-1:0]  size_r, cnt_c;
    logic [DATA_W-1:0] data_r, rd_data;
    logic              done_r, busy, done_flag;
    logic [7:0]        offset;
    logic              wr_en, rd_en, start_go;
    logic              unused_bits;
`ifdef DMAC_IRQ_EN
    logic              int_r;
`endif

    assign offset      = s_bus.s_addr[7:0];
    assign wr_en       = s_bus.s_sel & s_bus.s_wr;
    assign rd_en       = s_bus.s_sel & ~s_bus.s_wr;
    assign busy        = (state == REQ) || (state == RD) || (state == RWAIT) || (state == WR);
    assign done_flag   = done_r | (state == DONE);
    assign start_go    = wr_en & (state == IDLE) & (offset == 8'h00) & s_bus.s_din[0];
    assign unused_bits = ^{s_bus.s_addr[ADDR_W-1:8], s_bus.s_din[DATA_W-1:ADDR_W]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // A grant loss in RD/RWAIT/WR simply holds the state, so outputs stay put until grant returns.
    always_comb begin
        state_nxt     = state;
        m_bus.m_req   = 1'b0;
        m_bus.m_wr    = 1'b0;
        m_bus.m_addr  = '0;
        m_bus.m_dout  = '0;
        case (state)
            IDLE:  if (start_go) state_nxt = (size_r == '0) ? DONE : REQ;
            REQ: begin
                m_bus.m_req = 1'b1;
                if (m_bus.m_grant) state_nxt = RD;
            end
            RD: begin
                m_bus.m_req  = 1'b1;
                m_bus.m_addr = src_c;
                if (m_bus.m_grant) state_nxt = RWAIT;
            end
            RWAIT: begin
                m_bus.m_req  = 1'b1;
                m_bus.m_addr = src_c;
                if (m_bus.m_grant) state_nxt = WR;
            end
            WR: begin
                m_bus.m_req  = 1'b1;
                m_bus.m_wr   = 1'b1;
                m_bus.m_addr = dst_c;
                m_bus.m_dout = data_r;
                if (m_bus.m_grant) state_nxt = (cnt_c == CNT_W'(1)) ? DONE : RD;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            8'h01:   rd_data = DATA_W'(src_r);
            8'h02:   rd_data = DATA_W'(dst_r);
            8'h03:   rd_data = DATA_W'(size_r);
            8'h04:   rd_data = DATA_W'({done_flag, busy});
`ifdef DMAC_IRQ_EN
            8'h05:   rd_data = DATA_W'(int_r);
`endif
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_r  <= '0;
            dst_r  <= '0;
            size_r <= '0;
            src_c  <= '0;
            dst_c  <= '0;
            cnt_c  <= '0;
            data_r <= '0;
            done_r <= 1'b0;
            s_bus.s_dout <= '0;
        end else begin
            if (wr_en && !busy) begin
                case (offset)
                    8'h01:   src_r  <= s_bus.s_din[ADDR_W-1:0];
                    8'h02:   dst_r  <= s_bus.s_din[ADDR_W-1:0];
                    8'h03:   size_r <= s_bus.s_din[CNT_W-1:0];
                    default: ;
                endcase
            end
            if (start_go) begin
                src_c  <= src_r;
                dst_c  <= dst_r;
                cnt_c  <= size_r;
                done_r <= 1'b0;
            end else if (state == DONE) begin
                done_r <= 1'b1;
            end
            if (state == RWAIT && m_bus.m_grant) data_r <= m_bus.m_din;
            // Working addresses wrap naturally at 2^ADDR_W.
            if (state == WR && m_bus.m_grant) begin
                src_c <= src_c + ADDR_W'(1);
                dst_c <= dst_c + ADDR_W'(1);
                cnt_c <= cnt_c - CNT_W'(1);
            end
            s_bus.s_dout <= rd_en ? rd_data : '0;
        end
    end

`ifdef DMAC_IRQ_EN
    // Completion set takes priority over a same-cycle software clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                          int_r <= 1'b0;
        else if (state == DONE)                                int_r <= 1'b1;
        else if (wr_en && offset == 8'h05 && s_bus.s_din[0])   int_r <= 1'b0;
    end
    assign dma_irq = int_r;
`endif
endmodule
